mips_bus_master: RTL and testbench
==================================

# mips_bus_master

Parametrised bus interface unit between the multicycle MIPS core and the Avalon-style memory bus. It arbitrates between an instruction-fetch port and a load/store data port, and runs one bus transaction at a time, including `waitrequest` stalls. It generates `byteenable` for byte, half and word accesses (and double on 64-bit buses), lane-aligns store data, and sign- or zero-extends load data. It replaces the core's direct bus wiring and is instantiated inside `mips_cpu_bus`.

## Interface
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, bus data width; 32 or 64 only. `BE_W = DATA_W/8`, `OFF = log2(BE_W)`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request, level, held until `if_done`.
- `if_addr` in ADDR_W: fetch address; fetch size is always word.
- `if_done` out 1: one-cycle completion pulse.
- `if_rdata` out 32: fetched word, valid while `if_done`.
- `d_req` in 1: data request, level, held until `d_done`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double (legal only when DATA_W = 64).
- `d_unsigned` in 1: zero-extend loads when 1; sign-extend when 0.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in DATA_W: store data, right-justified.
- `d_done` out 1: one-cycle completion pulse.
- `d_rdata` out DATA_W: extended load data, valid while `d_done`.
- `d_err` out 1: misaligned access; valid with `d_done`.
- `busy` out 1: high in every state except IDLE.
- `address` out ADDR_W: bus address, always `BE_W`-aligned.
- `read` out 1: bus read strobe.
- `write` out 1: bus write strobe.
- `waitrequest` in 1: slave stall.
- `writedata` out DATA_W: lane-aligned store data.
- `byteenable` out BE_W: active byte lanes.
- `readdata` in DATA_W: bus read data.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If `d_req` is high, latch the data request and go to ACCESS. Otherwise, if `if_req` is high, latch the fetch request and go to ACCESS.
  - Data has priority when both requests are high. Latch the requesting port id.
- ACCESS:
  - Drive `read` or `write` from registers, and hold `address`, `byteenable` and `writedata` stable.
  - When `waitrequest` is 0, capture `readdata` into a register and go to DONE.
  - When `waitrequest` is 1, stay in ACCESS indefinitely.
- DONE:
  - Pulse `done` for the latched port, present the registered rdata, and drop the bus strobes.
  - Always return to IDLE.
  - The core deasserts `req` during the DONE cycle. A request still high in IDLE starts a new access.
- Lane arithmetic (little-endian):
  - `lo = addr[OFF-1:0]`, `nbytes = 1 << size`.
  - `byteenable = ((1 << nbytes) - 1) << lo`.
  - `writedata = d_wdata << (8*lo)`.
  - Load data is `readdata >> (8*lo)`, truncated to `8*nbytes` bits, then sign- or zero-extended to DATA_W.
- `d_size = 3` with DATA_W = 32 is treated as word.
- Reset values: state IDLE; `read`, `write`, `busy`, `if_done`, `d_done` and `d_err` all 0; `address`, `writedata`, `byteenable`, `if_rdata` and `d_rdata` all 0.
- Reset during ACCESS abandons the transaction. Strobes are low on the cycle after the reset edge, and no `done` pulse is issued.

## Timing
- Request sampled in IDLE at cycle 0, strobes high in cycle 1, zero-wait completion in cycle 1, `done` in cycle 2. Minimum latency is 2 cycles.
- Each cycle of `waitrequest` = 1 adds one cycle of latency.
- Back-to-back accesses: one IDLE cycle separates consecutive bus transactions, so the throughput ceiling is one access per 3 cycles.
- `readdata` is sampled only in the ACCESS cycle where `waitrequest` = 0. Its value in any other cycle is ignored.

## Configuration
- Macro: `MIPS_BUS_MISALIGN_TRAP_EN`.
- Defined:
  - A request whose `lo` is not a multiple of `nbytes` goes IDLE→DONE with no bus cycle.
  - Raises `d_err` = 1 with `d_done`, and `d_rdata` = 0.
  - A misaligned fetch raises `if_done` with `if_rdata` = 0 (fetch has no error output; the core checks the PC itself).
- Undefined: `lo` is forced down to alignment (`lo & ~(nbytes-1)`), the access proceeds normally, and `d_err` is tied to 0.

## Structure
- Shared package `mips_bus_pkg`: `size_t` enum (BYTE, HALF, WORD, DOUBLE), `bus_state_t` enum, and a `port_t` enum (PORT_IF, PORT_D).
- Sub-module `mips_bus_lane` (combinational): computes `byteenable`, `writedata` alignment and load extraction/extension from `lo`, size, `d_unsigned`, wdata and readdata. It is instantiated once in the master.
- FSM, arbiter and registers live in `mips_bus_master`.

## Test plan
- Word load, `d_addr` = 0x100, `waitrequest` low, `readdata` = 0xDEADBEEF → `read` high 1 cycle, `address` = 0x100, `byteenable` = 4'b1111, `d_done` 2 cycles after request, `d_rdata` = 0xDEADBEEF.
- Signed byte load at 0x103 with `readdata` = 0x80000000 → `byteenable` = 4'b1000, `d_rdata` = 0xFFFFFF80. Same access with `d_unsigned` = 1 → 0x00000080.
- Half store at 0x102 with `d_wdata` = 0x0000ABCD and `waitrequest` high for 3 cycles → `write` held 4 cycles, `writedata` = 0xABCD0000, `byteenable` = 4'b1100, `d_done` in cycle 5.
- `if_req` and `d_req` rise in the same cycle → data access first, then one IDLE cycle, then the fetch. Each port gets exactly one `done`.
- Word load at 0x102: with the macro defined → no `read`, `d_err` = 1 with `d_done`. Undefined → `address` = 0x100, `byteenable` = 4'b1111, `d_err` = 0.
- `reset` asserted during ACCESS with `waitrequest` high → `read` = 0 next cycle, `busy` = 0, no `done` pulse, and a subsequent fetch completes normally.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS bus interface unit: access sizes, FSM states and
// requester identity.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } bus_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  // Number of bytes moved by an access of the given size.
  function automatic logic [3:0] size_bytes(size_t s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/mips_bus_lane.sv
// Byte-lane steering for the bus master: byteenable generation, store data
// alignment and load data extraction with sign/zero extension (little-endian).
module mips_bus_lane
  import mips_bus_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF    = $clog2(BE_W)
) (
  input  logic [OFF-1:0]    lo_i,
  input  size_t             size_i,
  input  logic              uns_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_al_o,
  output logic [DATA_W-1:0] rdata_ext_o
);

  localparam int IW = $clog2(DATA_W);

  logic [3:0]        nbytes;
  logic [6:0]        nbits;
  logic [8:0]        full;
  logic [DATA_W-1:0] shifted;
  logic [IW-1:0]     top_idx;
  logic              sign;

  // Lane masks, store shift and load extract/extend are purely combinational.
  always_comb begin
    nbytes      = size_bytes(size_i);
    nbits       = {nbytes, 3'b000};
    full        = (9'd1 << nbytes) - 9'd1;
    be_o        = full[BE_W-1:0] << lo_i;
    wdata_al_o  = wdata_i << {lo_i, 3'b000};
    shifted     = rdata_i >> {lo_i, 3'b000};
    top_idx     = IW'(nbits - 7'd1);
    sign        = shifted[top_idx] & ~uns_i;
    rdata_ext_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rdata_ext_o[i] = (i < int'(nbits)) ? shifted[i] : sign;
    end
  end

endmodule

// File: rtl/mips_bus_master.sv
// Bus interface unit between the multicycle MIPS core and an Avalon-style bus.
// Arbitrates fetch vs. data (data wins), runs one transaction at a time and
// honours waitrequest. Optional macro MIPS_BUS_MISALIGN_TRAP_EN: misaligned
// requests skip the bus and complete with d_err; otherwise the byte offset is
// forced down to the access alignment.
module mips_bus_master
  import mips_bus_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF    = $clog2(BE_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [DATA_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] readdata
);

  bus_state_t        state_q, state_d;
  port_t             port_q;
  logic              we_q, uns_q, err_q;
  size_t             size_q;
  logic [OFF-1:0]    lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, d_rdata_q;
  logic [31:0]       if_rdata_q;

  logic              sel_d, req_any, trap;
  size_t             req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [OFF-1:0]    req_lo, req_mask;

  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wdata, lane_rdata;

  // Arbitration and request decode; only meaningful while IDLE.
  always_comb begin
    sel_d    = d_req;
    req_any  = d_req | if_req;
    req_addr = sel_d ? d_addr : if_addr;
    if (!sel_d)                               req_size = WORD;
    else if (DATA_W == 32 && d_size == 2'd3)  req_size = WORD;
    else                                      req_size = size_t'(d_size);
    req_lo   = req_addr[OFF-1:0];
    req_mask = OFF'(size_bytes(req_size) - 4'd1);
`ifdef MIPS_BUS_MISALIGN_TRAP_EN
    trap     = |(req_lo & req_mask);
`else
    trap     = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_any) state_d = trap ? S_DONE : S_ACCESS;
      S_ACCESS: if (!waitrequest) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request latch in IDLE and read-data capture on the accepting ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= BYTE;
      lo_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      d_rdata_q  <= '0;
      if_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_any) begin
          port_q  <= sel_d ? PORT_D : PORT_IF;
          we_q    <= sel_d & d_we;
          uns_q   <= sel_d ? d_unsigned : 1'b1;
          err_q   <= trap;
          size_q  <= req_size;
          lo_q    <= req_lo & ~req_mask;
          addr_q  <= {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
          wdata_q <= sel_d ? d_wdata : '0;
          if (trap) begin
            if (sel_d) d_rdata_q  <= '0;
            else       if_rdata_q <= '0;
          end
        end
        S_ACCESS: if (!waitrequest) begin
          if (port_q == PORT_D) d_rdata_q  <= lane_rdata;
          else                  if_rdata_q <= lane_rdata[31:0];
        end
        default: ;
      endcase
    end
  end

  mips_bus_lane #(.DATA_W(DATA_W)) u_lane (
    .lo_i       (lo_q),
    .size_i     (size_q),
    .uns_i      (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (readdata),
    .be_o       (lane_be),
    .wdata_al_o (lane_wdata),
    .rdata_ext_o(lane_rdata)
  );

  // Outputs decoded from state; strobes and lanes only live in ACCESS.
  always_comb begin
    busy       = (state_q != S_IDLE);
    read       = (state_q == S_ACCESS) & ~we_q;
    write      = (state_q == S_ACCESS) & we_q;
    if_done    = (state_q == S_DONE) & (port_q == PORT_IF);
    d_done     = (state_q == S_DONE) & (port_q == PORT_D);
    d_err      = d_done & err_q;
    byteenable = (state_q == S_ACCESS) ? lane_be : '0;
    address    = addr_q;
    writedata  = lane_wdata;
    if_rdata   = if_rdata_q;
    d_rdata    = d_rdata_q;
  end

endmodule

// File: tb/tb_mips_bus_master.sv
// Scoreboard bench for mips_bus_master: a byte-array reference model predicts
// bus transactions and completions; a bus slave and a completion monitor
// check them independently of the stimulus.
module tb_mips_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        if_done, d_done, d_err, busy, read, write;
  logic [31:0] if_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  mips_bus_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .d_err(d_err), .busy(busy), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct { logic [31:0] addr; logic [3:0] be; bit we; logic [31:0] wdata; int waits; } btx_t;
  typedef struct { logic [31:0] data; bit err; bit chk_data; int cyc; } rsp_t;

  btx_t bq[$];
  rsp_t dq[$], iq[$];

  logic [7:0]  ref_mem [256];
  logic [31:0] bus_mem [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    bus_mem[a[7:2]] = v;
    for (int i = 0; i < 4; i++) ref_mem[int'(a & 32'hFC) + i] = v[8*i +: 8];
  endtask

  // Reference model: bytes in memory, little-endian, plain arithmetic.
  task automatic model(input bit is_d, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input int waits,
                       input int c, output rsp_t r, output btx_t t, output bit bus);
    int n, lo, base;
    bit mis;
    logic [63:0] v;
    n    = (!is_d || sz == 2'd3) ? 4 : (1 << sz);
    lo   = int'(a % 4);
    mis  = (lo % n) != 0;
    lo   = lo - (lo % n);
    base = int'(a & 32'hFF) - int'(a % 4);
`ifdef MIPS_BUS_MISALIGN_TRAP_EN
    bus = !mis;
`else
    bus = 1'b1;
`endif
    t.addr  = a - (a % 4);
    t.be    = 4'(((1 << n) - 1) << lo);
    t.we    = is_d && we;
    t.wdata = wd << (8 * lo);
    t.waits = waits;
    r.err = 1'b0; r.data = '0; r.chk_data = 1'b1;
    if (!bus) begin
      r.err = is_d;
      r.cyc = c + 1;
    end else begin
      r.cyc = c + 2 + waits;
      if (t.we) begin
        r.chk_data = 1'b0;
        for (int i = 0; i < n; i++) ref_mem[base + lo + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[base + lo + i]) << (8 * i));
        if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        r.data = v[31:0];
      end
    end
  endtask

  // Bus slave: stalls as the expected transaction dictates, checks the
  // transaction when it accepts it, and applies writes to its own memory.
  int wcnt = 0, scnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      wcnt = 0; scnt = 0; waitrequest = 1'b0;
    end else if (read || write) begin
      scnt++;
      if (bq.size() == 0) begin
        flag("bus_unexpected_strobe");
        waitrequest = 1'b0;
      end else if (wcnt < bq[0].waits) begin
        wcnt++;
        waitrequest = 1'b1;
        readdata = $urandom;
      end else begin
        btx_t t;
        t = bq.pop_front();
        waitrequest = 1'b0;
        chk("bus_address", address, t.addr);
        chk("bus_byteenable", byteenable, t.be);
        chk("bus_write", write, t.we);
        chk("bus_read", read, !t.we);
        chk("bus_strobe_cycles", scnt, t.waits + 1);
        if (t.we) begin
          chk("bus_writedata", writedata, t.wdata);
          for (int i = 0; i < 4; i++)
            if (byteenable[i]) bus_mem[address[7:2]][8*i +: 8] = writedata[8*i +: 8];
          readdata = $urandom;
        end else begin
          readdata = bus_mem[address[7:2]];
        end
        wcnt = 0; scnt = 0;
      end
    end else begin
      scnt = 0;
      waitrequest = 1'($urandom);
      readdata = $urandom;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (d_done) begin
        if (dq.size() == 0) flag("d_done_unexpected");
        else begin
          rsp_t r;
          r = dq.pop_front();
          chk("d_done_cycle", 64'(cyc), 64'(r.cyc));
          chk("d_err", d_err, r.err);
          if (r.chk_data) chk("d_rdata", d_rdata, r.data);
        end
      end
      if (if_done) begin
        if (iq.size() == 0) flag("if_done_unexpected");
        else begin
          rsp_t r;
          r = iq.pop_front();
          chk("if_done_cycle", 64'(cyc), 64'(r.cyc));
          chk("if_rdata", if_rdata, r.data);
        end
      end
    end
  end

  task automatic do_acc(input bit is_d, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input int waits);
    rsp_t r; btx_t t; bit bus; bit seen;
    model(is_d, we, sz, uns, a, wd, waits, cyc, r, t, bus);
    if (bus) bq.push_back(t);
    if (is_d) begin
      dq.push_back(r);
      d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
    end else begin
      iq.push_back(r);
      if_req = 1'b1; if_addr = a;
    end
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = is_d ? d_done : if_done;
    end
    if (!seen) flag("done_timeout");
    d_req = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) set_word(32'(i * 4), $urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read", read, 0);            chk("rst_write", write, 0);
    chk("rst_busy", busy, 0);            chk("rst_if_done", if_done, 0);
    chk("rst_d_done", d_done, 0);        chk("rst_d_err", d_err, 0);
    chk("rst_address", address, 0);      chk("rst_writedata", writedata, 0);
    chk("rst_byteenable", byteenable, 0);
    chk("rst_if_rdata", if_rdata, 0);    chk("rst_d_rdata", d_rdata, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    set_word(32'h100, 32'hDEADBEEF);
    do_acc(1, 0, 2'd2, 0, 32'h100, 0, 0);
    set_word(32'h100, 32'h80000000);
    do_acc(1, 0, 2'd0, 0, 32'h103, 0, 0);
    do_acc(1, 0, 2'd0, 1, 32'h103, 0, 0);
    do_acc(1, 1, 2'd1, 0, 32'h102, 32'h0000ABCD, 3);
    do_acc(1, 0, 2'd2, 1, 32'h100, 0, 0);
    do_acc(1, 0, 2'd2, 0, 32'h102, 0, 0);
    do_acc(1, 0, 2'd3, 0, 32'h108, 0, 1);

    // Simultaneous fetch and data request: data first, then fetch.
    begin
      rsp_t rd, rf; btx_t td, tf; bit bd, bf; int c;
      c = cyc;
      model(1, 0, 2'd2, 0, 32'h104, 0, 0, c, rd, td, bd);
      model(0, 0, 2'd2, 1, 32'h108, 0, 0, c + 3, rf, tf, bf);
      bq.push_back(td); bq.push_back(tf);
      dq.push_back(rd); iq.push_back(rf);
      d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h104;
      if_req = 1'b1; if_addr = 32'h108;
      for (int k = 0; k < 40 && (d_req || if_req); k++) begin
        @(negedge clk);
        if (d_done) d_req = 1'b0;
        if (if_done) if_req = 1'b0;
      end
      if (d_req || if_req) flag("dual_timeout");
      d_req = 1'b0; if_req = 1'b0;
      @(posedge clk); #1;
    end

    // Reset in the middle of a stalled fetch abandons it.
    begin
      rsp_t r; btx_t t; bit bus; bit seen;
      model(0, 0, 2'd2, 1, 32'h110, 0, 10, cyc, r, t, bus);
      bq.push_back(t);
      if_req = 1'b1; if_addr = 32'h110;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = read;
      end
      if (!seen) flag("reset_case_no_read");
      @(posedge clk); #1;
      reset = 1'b1; if_req = 1'b0;
      @(posedge clk); #1;
      chk("reset_mid_read", read, 0);
      chk("reset_mid_busy", busy, 0);
      chk("reset_mid_if_done", if_done, 0);
      bq.delete();
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("after_reset_busy", busy, 0);
      do_acc(0, 0, 2'd2, 1, 32'h110, 0, 1);
    end

    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      bit is_d;
      logic [31:0] a;
      is_d = ($urandom % 4) != 0;
      a = 32'h100 + ($urandom % 64);
      do_acc(is_d, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, int'($urandom % 4));
    end

    repeat (3) @(posedge clk);
    if (bq.size() != 0 || dq.size() != 0 || iq.size() != 0) flag("scoreboard_not_empty");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
